// File: rtl/imem_arbiter.sv
// Two-requester arbiter for the single-ported instruction memory: fetch (read-only)
// and loader/debug (read/write), round-robin with a bounded loader lock.
module imem_arbiter #(
   parameter int ADDR_W   = 6,
   parameter int DATA_W   = 32,
   parameter int MAX_LOCK = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_gnt,
   output logic              f_rvalid,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              l_req,
   input  logic              l_we,
   input  logic              l_lock,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   // state    | meaning
   // OWN_NONE | no read in flight, mem_rdata belongs to nobody
   // OWN_F    | fetch read issued last cycle, mem_rdata routed to fetch
   // OWN_L    | loader read issued last cycle, mem_rdata routed to loader
   typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_L} owner_t;

   localparam int CNT_W = $clog2(MAX_LOCK + 1);

   owner_t           owner;
   logic             last_l;
   logic [CNT_W-1:0] lock_cnt;
   logic             lock_full;

   assign lock_full = (lock_cnt == CNT_W'(MAX_LOCK));

   always_comb begin
      f_gnt = 1'b0;
      l_gnt = 1'b0;
      if (rst) begin
         if (f_req && l_req) begin
            if (l_lock) begin
               if (lock_full) f_gnt = 1'b1;
               else           l_gnt = 1'b1;
            end else if (last_l) begin
               f_gnt = 1'b1;
            end else begin
               l_gnt = 1'b1;
            end
         end else if (f_req) begin
            f_gnt = 1'b1;
         end else if (l_req) begin
            l_gnt = 1'b1;
         end
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (f_gnt) begin
         mem_en   = 1'b1;
         mem_addr = f_addr;
      end else if (l_gnt) begin
         mem_en    = 1'b1;
         mem_we    = l_we;
         mem_addr  = l_addr;
         mem_wdata = l_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         owner    <= OWN_NONE;
         last_l   <= 1'b1;
         lock_cnt <= '0;
      end else begin
         if (f_gnt)      last_l <= 1'b0;
         else if (l_gnt) last_l <= 1'b1;

         // A fetch grant under lock only happens once the counter is full.
         if (!l_lock || !l_req || f_gnt) lock_cnt <= '0;
         else if (l_gnt && !lock_full)   lock_cnt <= lock_cnt + 1'b1;

         if (f_gnt)              owner <= OWN_F;
         else if (l_gnt && !l_we) owner <= OWN_L;
         else                    owner <= OWN_NONE;
      end
   end

   // Gating with rst drops a read that was in flight when reset arrived.
   assign f_rvalid = (owner == OWN_F) && rst;
   assign l_rvalid = (owner == OWN_L) && rst;
   assign f_rdata  = f_rvalid ? mem_rdata : '0;
   assign l_rdata  = l_rvalid ? mem_rdata : '0;

endmodule
